// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared types and constants for the UART/SRAM transmit and receive paths.
// UART_TX_PARITY_EN widens the serial frame by one even-parity bit.
package uart_sram_tx_interface_pkg;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_DONE
  } tx_state_type;

  localparam int UART_BAUD_DIV     = 434;
  localparam int SRAM_READ_LATENCY = 3;
  localparam int SRAM_ADDR_W       = 18;

`ifdef UART_TX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sram_tx_interface_uart_tx_byte.sv
// Single-byte serializer: start bit, d0..d7, optional even parity
// (UART_TX_PARITY_EN), stop bit; each bit held BAUD_DIV cycles.
module uart_tx_byte
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       TX,
  output logic       Tx_done
);

  localparam int BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int NB     = UART_FRAME_BITS;

  logic [BAUD_W-1:0] r_baud_cnt;
  logic [3:0]        r_bit_cnt;
  logic [NB-2:0]     r_shift;
  logic              r_tx;
  logic              r_active;
  logic [NB-1:0]     w_frame;
  logic              w_last;

`ifdef UART_TX_PARITY_EN
  assign w_frame = {1'b1, even_parity(Data), Data, 1'b0};
`else
  assign w_frame = {1'b1, Data, 1'b0};
`endif

  // Last cycle of the stop bit; a Load here chains the next frame with no gap.
  assign w_last  = r_active && (r_baud_cnt == '0) && (r_bit_cnt == 4'(NB - 1));
  assign Tx_done = w_last;
  assign TX      = r_tx;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '1;
      r_tx       <= 1'b1;
      r_active   <= 1'b0;
    end else if (Load && (!r_active || w_last)) begin
      r_tx       <= w_frame[0];
      r_shift    <= w_frame[NB-1:1];
      r_bit_cnt  <= '0;
      r_baud_cnt <= BAUD_W'(BAUD_DIV - 1);
      r_active   <= 1'b1;
    end else if (r_active) begin
      if (r_baud_cnt != '0) begin
        r_baud_cnt <= r_baud_cnt - 1'b1;
      end else if (w_last) begin
        r_active <= 1'b0;
        r_tx     <= 1'b1;
      end else begin
        r_baud_cnt <= BAUD_W'(BAUD_DIV - 1);
        r_bit_cnt  <= r_bit_cnt + 1'b1;
        r_tx       <= r_shift[0];
        r_shift    <= {1'b1, r_shift[NB-2:1]};
      end
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads Word_count SRAM words from Base_address and sends each as two UART
// bytes, high byte first. Frame format set by UART_TX_PARITY_EN in the package.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int BAUD_DIV    = UART_BAUD_DIV,
  parameter int SRAM_RD_LAT = SRAM_READ_LATENCY
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Base_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int RD_CNT_W = (SRAM_RD_LAT > 0) ? $clog2(SRAM_RD_LAT + 1) : 1;

  tx_state_type          r_state, w_state_next;
  logic [17:0]           r_addr, w_addr_next;
  logic [17:0]           r_remaining, w_remaining_next;
  logic [7:0]            r_word_lo, w_word_lo_next;
  logic [RD_CNT_W-1:0]   r_rd_cnt, w_rd_cnt_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic                  w_load;
  logic [7:0]            w_load_data;
  logic                  w_tx_done;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_TX_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_word_lo   <= '0;
      r_rd_cnt    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_word_lo   <= w_word_lo_next;
      r_rd_cnt    <= w_rd_cnt_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_word_lo_next   = r_word_lo;
    w_rd_cnt_next    = r_rd_cnt;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_load           = 1'b0;
    w_load_data      = r_word_lo;

    case (r_state)
      S_TX_IDLE: begin
        if (Start) begin
          w_busy_next      = 1'b1;
          w_remaining_next = Word_count;
          if (Word_count == '0) begin
            w_state_next = S_TX_DONE;
          end else begin
            w_addr_next   = Base_address;
            w_rd_cnt_next = '0;
            w_state_next  = S_TX_READ;
          end
        end
      end
      S_TX_READ: begin
        // High byte goes straight to the serializer; only the low byte needs holding.
        if (r_rd_cnt == RD_CNT_W'(SRAM_RD_LAT)) begin
          w_word_lo_next = SRAM_read_data[7:0];
          w_load         = 1'b1;
          w_load_data    = SRAM_read_data[15:8];
          w_state_next   = S_TX_SEND_HI;
        end else begin
          w_rd_cnt_next = r_rd_cnt + 1'b1;
        end
      end
      S_TX_SEND_HI: begin
        if (w_tx_done) begin
          w_load       = 1'b1;
          w_load_data  = r_word_lo;
          w_state_next = S_TX_SEND_LO;
        end
      end
      S_TX_SEND_LO: begin
        if (w_tx_done) begin
          w_remaining_next = r_remaining - 1'b1;
          if (r_remaining == 18'd1) begin
            w_state_next = S_TX_DONE;
          end else begin
            w_addr_next   = r_addr + 1'b1;
            w_rd_cnt_next = '0;
            w_state_next  = S_TX_READ;
          end
        end
      end
      S_TX_DONE: begin
        w_busy_next  = 1'b0;
        w_done_next  = 1'b1;
        w_state_next = S_TX_IDLE;
      end
      default: begin
        w_state_next = S_TX_IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Load    (w_load),
    .Data    (w_load_data),
    .TX      (UART_TX_O),
    .Tx_done (w_tx_done)
  );

  assign SRAM_address = r_addr;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = r_busy;
  assign Done         = r_done;

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: vector table of transfers, a serial-line
// decoder feeding a scoreboard, plus a mid-frame reset sequence.
module tb_uart_sram_tx_interface;

  localparam int B   = 50;
  localparam int LAT = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FB   = NBITS * B;
  localparam int WORD = 2 * FB + LAT + 1;

  typedef struct {
    logic [17:0] base;
    logic [17:0] cnt;
    int          done_rel;
    logic [17:0] last_addr;
    bit          extra_start;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    longint     start;
  } sb_t;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic [17:0] Base_address;
  logic [17:0] Word_count;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic        UART_TX_O;
  logic        Busy;
  logic        Done;

  uart_sram_tx_interface #(
    .BAUD_DIV    (B),
    .SRAM_RD_LAT (LAT)
  ) dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Start          (Start),
    .Base_address   (Base_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #5 Clock = ~Clock;

  longint cycle_cnt = 0;
  always @(posedge Clock) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    case (a)
      18'h00010: return 16'h4142;
      18'h00020: return 16'h4143;
      default:   return {a[7:0] ^ 8'h5A, a[15:8] ^ a[7:0] ^ {6'b0, a[17:16]}};
    endcase
  endfunction

  // SRAM model: data appears LAT cycles after the address is presented
  logic [17:0] addr_pipe [LAT];
  always @(posedge Clock) begin
    addr_pipe[0] <= SRAM_address;
    for (int k = 1; k < LAT; k++) addr_pipe[k] <= addr_pipe[k-1];
  end
  assign SRAM_read_data = mem_word(addr_pipe[LAT-1]);

  int  n_checks  = 0;
  int  n_fail    = 0;
  int  done_cnt  = 0;
  int  frames_rx = 0;
  sb_t sb_q[$];

  always @(negedge Clock) if (Done) done_cnt++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Serial decoder: samples mid-bit, drops any frame that a reset interrupts
  initial begin
    logic             prev_tx;
    logic [NBITS-1:0] mbits;
    longint           start_c;
    bit               aborted;
    sb_t              e;
    prev_tx = 1'b1;
    forever begin
      @(negedge Clock);
      if (Resetn && prev_tx && !UART_TX_O) begin
        start_c = cycle_cnt;
        aborted = 1'b0;
        for (int b = 0; b < NBITS; b++) begin
          for (int c = 0; c < ((b == 0) ? B / 2 : B); c++) begin
            @(negedge Clock);
            if (!Resetn) aborted = 1'b1;
          end
          mbits[b] = UART_TX_O;
        end
        prev_tx = 1'b1;
        if (!aborted) begin
          frames_rx++;
          check("frame_expected", longint'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            $display("frame %0d: byte %02h at cycle %0d (expected %02h at %0d)",
                     frames_rx, mbits[8:1], start_c, e.data, e.start);
            check("frame_start_bit", mbits[0], 0);
            check("frame_data", mbits[8:1], e.data);
            check("frame_start_cycle", start_c, e.start);
            check("frame_stop_bit", mbits[NBITS-1], 1);
`ifdef UART_TX_PARITY_EN
            check("frame_parity", mbits[9], ^e.data);
`endif
          end
        end
      end else begin
        prev_tx = UART_TX_O;
      end
    end
  end

  task automatic run_xfer(input vec_t v);
    longint      t0;
    int          rel, gaps, done0, frames0;
    bit          got;
    logic [17:0] a;
    logic [15:0] w;
    @(negedge Clock);
    Base_address = v.base;
    Word_count   = v.cnt;
    Start        = 1'b1;
    t0      = cycle_cnt;
    done0   = done_cnt;
    frames0 = frames_rx;
    for (int k = 0; k < int'(v.cnt); k++) begin
      a = v.base + 18'(k);
      w = mem_word(a);
      sb_q.push_back('{w[15:8], t0 + 5 + longint'(k) * WORD});
      sb_q.push_back('{w[7:0],  t0 + 5 + longint'(k) * WORD + FB});
    end
    @(negedge Clock);
    Start = 1'b0;
    check("busy_rise", Busy, 1);
    check("addr_first", SRAM_address, (v.cnt != 0) ? v.base : v.last_addr);
    gaps = 0;
    got  = 1'b0;
    rel  = 1;
    for (int i = 0; i < v.done_rel + 50; i++) begin
      rel = int'(cycle_cnt - t0);
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (!Busy) gaps++;
      if (v.extra_start && rel == 100) begin
        Base_address = 18'h0AAAA;
        Word_count   = 18'd5;
        Start        = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    $display("xfer base=%05h cnt=%0d: done at +%0d (expected +%0d), addr=%05h",
             v.base, v.cnt, rel, v.done_rel, SRAM_address);
    check("done_seen", got, 1);
    check("done_cycle", rel, v.done_rel);
    check("busy_in_done", Busy, 0);
    check("busy_gaps", gaps, 0);
    check("last_addr", SRAM_address, v.last_addr);
    repeat (2 * FB + 20) @(negedge Clock);
    check("done_count", done_cnt - done0, 1);
    check("frame_count", frames_rx - frames0, 2 * int'(v.cnt));
    check("sb_empty", sb_q.size(), 0);
    check("we_n", SRAM_we_n, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[5];
    longint t0;
    int     done0, frames0;

    vecs[0] = '{18'h00010, 18'd1, 2 + 1 * WORD, 18'h00010, 1'b0};
    vecs[1] = '{18'h3FFFF, 18'd3, 2 + 3 * WORD, 18'h00001, 1'b0};
    vecs[2] = '{18'h00123, 18'd0, 2,            18'h00001, 1'b0};
    vecs[3] = '{18'h00020, 18'd1, 2 + 1 * WORD, 18'h00020, 1'b0};
    vecs[4] = '{18'h00200, 18'd2, 2 + 2 * WORD, 18'h00201, 1'b1};

    Resetn       = 1'b1;
    Start        = 1'b0;
    Base_address = '0;
    Word_count   = '0;
    #2 Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    $display("reset: tx=%0b busy=%0b done=%0b addr=%05h we_n=%0b",
             UART_TX_O, Busy, Done, SRAM_address, SRAM_we_n);
    check("reset_tx", UART_TX_O, 1);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_addr", SRAM_address, 0);
    check("reset_we_n", SRAM_we_n, 1);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock);

    for (int i = 0; i < 5; i++) run_xfer(vecs[i]);

    // Reset during d4 of the first byte (a 0 bit of 0x41)
    @(negedge Clock);
    Base_address = 18'h00010;
    Word_count   = 18'd1;
    Start        = 1'b1;
    t0 = cycle_cnt;
    sb_q.push_back('{8'h41, t0 + 5});
    @(negedge Clock);
    Start = 1'b0;
    while (int'(cycle_cnt - t0) < 5 + 5 * B + B / 2) @(negedge Clock);
    check("tx_mid_frame", UART_TX_O, 0);
    done0   = done_cnt;
    frames0 = frames_rx;
    #1 Resetn = 1'b0;
    #1;
    $display("mid-frame reset: tx=%0b busy=%0b done=%0b addr=%05h",
             UART_TX_O, Busy, Done, SRAM_address);
    check("rst_tx", UART_TX_O, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_addr", SRAM_address, 0);
    sb_q.delete();
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2 * FB) @(negedge Clock);
    check("rst_no_done", done_cnt - done0, 0);
    check("rst_no_frame", frames_rx - frames0, 0);
    run_xfer('{18'h00010, 18'd1, 2 + 1 * WORD, 18'h00010, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
